// File: rtl/disp_pkg.sv
// Shared types and constants for the display conversion scheduler.
package disp_pkg;

  localparam int BCD_W      = 4;
  localparam int DATA_W     = 8;
  localparam int CONV_STEPS = 8;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    HOLD
  } state_e;

  function automatic logic [BCD_W-1:0] add3(
    input logic [BCD_W-1:0] n
  );
    return (n > 4'd4) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/disp_rr_arbiter.sv
// Round-robin pick: first set req bit at or above ptr, wrapping.
module disp_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic [NREQ-1:0] pick,
  output logic [2:0]      idx
);

  logic found;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      for (int k = 0; k < NREQ; k++) begin
        if (!found && k == j && req[k]) begin
          found   = 1'b1;
          pick[k] = 1'b1;
          idx     = 3'(k);
        end
      end
    end
  end

endmodule

// File: rtl/disp_conv_sched.sv
// Shares one sequential binary-to-BCD converter among NREQ byte sources,
// round-robin arbitrated, with a programmable display hold time.
module disp_conv_sched
  import disp_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [DATA_W*NREQ-1:0] data_in,
  input  logic [NREQ-1:0]        signed_in,
  output logic [NREQ-1:0]        grant,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             src,
  output logic [BCD_W-1:0]       hundreds,
  output logic [BCD_W-1:0]       tens,
  output logic [BCD_W-1:0]       ones,
  output logic                   negative
);

  localparam int HW = $clog2(HOLD_CYCLES + 2);

  state_e            state_q, state_d;
  logic [2:0]        iter_q, iter_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [19:0]       sr_q, sr_d;
  logic              neg_lat_q, neg_lat_d;
  logic [2:0]        idx_q, idx_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [2:0]        src_q, src_d;
  logic [BCD_W-1:0]  hun_q, hun_d;
  logic [BCD_W-1:0]  ten_q, ten_d;
  logic [BCD_W-1:0]  one_q, one_d;
  logic              neg_q, neg_d;

  logic [NREQ-1:0]   pick;
  logic [2:0]        pick_idx;
  logic [DATA_W-1:0] byte_sel;
  logic              sgn_sel;
  logic [DATA_W-1:0] mag;
  logic [19:0]       sr_step;

  disp_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .idx  (pick_idx)
  );

  always_comb begin
    byte_sel = '0;
    sgn_sel  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        byte_sel = byte_sel | data_in[DATA_W*i +: DATA_W];
        sgn_sel  = sgn_sel | signed_in[i];
      end
    end
  end

  // 8-bit negation suffices: the largest magnitude, 128, still fits.
  assign mag = (sgn_sel && byte_sel[7]) ? (~byte_sel + 8'd1) : byte_sel;

  assign sr_step = {add3(sr_q[19:16]), add3(sr_q[15:12]),
                    add3(sr_q[11:8]), sr_q[7:0]} << 1;

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    hold_d    = hold_q;
    ptr_d     = ptr_q;
    sr_d      = sr_q;
    neg_lat_d = neg_lat_q;
    idx_d     = idx_q;
    grant_d   = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    src_d     = src_q;
    hun_d     = hun_q;
    ten_d     = ten_q;
    one_d     = one_q;
    neg_d     = neg_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d   = pick;
          busy_d    = 1'b1;
          state_d   = CONV;
          iter_d    = '0;
          idx_d     = pick_idx;
          ptr_d     = (pick_idx == 3'(NREQ - 1)) ? 3'd0
                                                 : pick_idx + 3'd1;
          sr_d      = {12'd0, mag};
          neg_lat_d = sgn_sel && byte_sel[7];
        end
      end
      CONV: begin
        sr_d   = sr_step;
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'(CONV_STEPS - 1)) begin
          hun_d  = sr_step[19:16];
          ten_d  = sr_step[15:12];
          one_d  = sr_step[11:8];
          neg_d  = neg_lat_q;
          src_d  = idx_q;
          done_d = 1'b1;
          if (HOLD_CYCLES == 0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = HOLD;
            hold_d  = HW'(HOLD_CYCLES);
          end
        end
      end
      HOLD: begin
        hold_d = hold_q - HW'(1);
        if (hold_q == HW'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      iter_q    <= '0;
      hold_q    <= '0;
      ptr_q     <= '0;
      sr_q      <= '0;
      neg_lat_q <= 1'b0;
      idx_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      src_q     <= '0;
      hun_q     <= '0;
      ten_q     <= '0;
      one_q     <= '0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      iter_q    <= iter_d;
      hold_q    <= hold_d;
      ptr_q     <= ptr_d;
      sr_q      <= sr_d;
      neg_lat_q <= neg_lat_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      src_q     <= src_d;
      hun_q     <= hun_d;
      ten_q     <= ten_d;
      one_q     <= one_d;
      neg_q     <= neg_d;
    end
  end

  assign grant    = grant_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign src      = src_q;
  assign hundreds = hun_q;
  assign tens     = ten_q;
  assign ones     = one_q;
  assign negative = neg_q;

endmodule

// File: tb/tb_disp_conv_sched.sv
// Directed bench: one DUT with a 16-cycle hold, one with no hold.
module tb_disp_conv_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [3:0]  req_a = '0, sgn_a = '0;
  logic [31:0] data_a = '0;
  logic [3:0]  grant_a;
  logic        busy_a, done_a, neg_a;
  logic [2:0]  src_a;
  logic [3:0]  hun_a, ten_a, one_a;

  logic [3:0]  req_b = '0, sgn_b = '0;
  logic [31:0] data_b = '0;
  logic [3:0]  grant_b;
  logic        busy_b, done_b, neg_b;
  logic [2:0]  src_b;
  logic [3:0]  hun_b, ten_b, one_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  disp_conv_sched #(.NREQ(4), .HOLD_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req(req_a), .data_in(data_a),
    .signed_in(sgn_a), .grant(grant_a), .busy(busy_a),
    .done(done_a), .src(src_a), .hundreds(hun_a), .tens(ten_a),
    .ones(one_a), .negative(neg_a)
  );

  disp_conv_sched #(.NREQ(4), .HOLD_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .data_in(data_b),
    .signed_in(sgn_b), .grant(grant_b), .busy(busy_b),
    .done(done_b), .src(src_b), .hundreds(hun_b), .tens(ten_b),
    .ones(one_b), .negative(neg_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy_a && c < 40) begin
      tick();
      c++;
    end
    n_chk++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout busy=%b want 0", busy_a);
    end
  endtask

  task automatic run_conv(input int k, input logic [7:0] b,
                          input logic s, output logic [3:0] h,
                          output logic [3:0] t, output logic [3:0] o,
                          output logic n, output logic [2:0] sr,
                          output int lat);
    data_a[8*k +: 8] = b;
    sgn_a = '0;
    sgn_a[k] = s;
    req_a = '0;
    req_a[k] = 1'b1;
    lat = 0;
    tick();
    req_a = '0;
    while (!done_a && lat < 20) begin
      tick();
      lat++;
    end
    h = hun_a; t = ten_a; o = one_a; n = neg_a; sr = src_a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({grant_a, busy_a, done_a, src_a, hun_a, ten_a, one_a, neg_a}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_a g=%b b=%b d=%b s=%0d %0d%0d%0d n=%b",
               grant_a, busy_a, done_a, src_a, hun_a, ten_a, one_a,
               neg_a);
    end
    n_chk++;
    if ({grant_b, busy_b, done_b, src_b, hun_b, ten_b, one_b, neg_b}
        !== '0) begin
      n_fail++;
      $display("FAIL reset_b g=%b b=%b d=%b", grant_b, busy_b, done_b);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int bad = 0;
    data_a[15:8] = 8'hFF;
    sgn_a = '0;
    req_a = 4'b0010;
    tick();
    req_a = '0;
    n_chk++;
    if (grant_a !== 4'b0010 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL grant1 g=%b b=%b want 0010 1", grant_a, busy_a);
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      if (done_a !== 1'b0 || grant_a !== 4'b0000) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL conv_quiet bad=%0d want 0", bad);
    end
    tick();
    n_chk++;
    if (done_a !== 1'b1 || hun_a !== 4'd2 || ten_a !== 4'd5 ||
        one_a !== 4'd5 || neg_a !== 1'b0 || src_a !== 3'd1) begin
      n_fail++;
      $display("FAIL ff_unsigned d=%b %0d%0d%0d n=%b s=%0d want 1 255 0 1",
               done_a, hun_a, ten_a, one_a, neg_a, src_a);
    end
    tick();
    n_chk++;
    if (done_a !== 1'b0 || hun_a !== 4'd2 || one_a !== 4'd5) begin
      n_fail++;
      $display("FAIL done_pulse d=%b h=%0d want 0 2", done_a, hun_a);
    end
    wait_idle();
  endtask

  task automatic test_signed();
    logic [7:0] bv [4] = '{8'hFF, 8'h80, 8'h7F, 8'h00};
    logic [3:0] eh [4] = '{4'd0, 4'd1, 4'd1, 4'd0};
    logic [3:0] et [4] = '{4'd0, 4'd2, 4'd2, 4'd0};
    logic [3:0] eo [4] = '{4'd1, 4'd8, 4'd7, 4'd0};
    logic       en [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] h, t, o;
    logic       n;
    logic [2:0] s;
    int         lat;
    for (int i = 0; i < 4; i++) begin
      run_conv(0, bv[i], 1'b1, h, t, o, n, s, lat);
      n_chk++;
      if (lat != 8 || h !== eh[i] || t !== et[i] || o !== eo[i] ||
          n !== en[i] || s !== 3'd0) begin
        n_fail++;
        $display("FAIL signed_%02h lat=%0d got %0d%0d%0d n=%b s=%0d want 8 %0d%0d%0d n=%b s=0",
                 bv[i], lat, h, t, o, n, s, eh[i], et[i], eo[i], en[i]);
      end
      wait_idle();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] gv [4];
    int         gt [4];
    logic [2:0] ds [3];
    logic [3:0] eg [4] = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
    logic [2:0] es [3] = '{3'd2, 3'd0, 3'd2};
    int t = 0, ng = 0, nd = 0;
    sgn_a = '0;
    data_a = 32'h0009_002A;
    req_a = 4'b0101;
    while (ng < 4 && t < 150) begin
      tick();
      t++;
      if (grant_a != 4'b0000) begin
        gv[ng] = grant_a;
        gt[ng] = t;
        ng++;
      end
      if (done_a && nd < 3) begin
        ds[nd] = src_a;
        nd++;
      end
    end
    req_a = '0;
    n_chk++;
    if (ng != 4 || nd != 3) begin
      n_fail++;
      $display("FAIL rr_count grants=%0d dones=%0d want 4 3", ng, nd);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (gv[i] !== eg[i]) begin
          n_fail++;
          $display("FAIL rr_grant%0d got %b want %b", i, gv[i], eg[i]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        n_chk++;
        if (gt[i+1] - gt[i] != 25 || ds[i] !== es[i]) begin
          n_fail++;
          $display("FAIL rr_gap%0d gap=%0d src=%0d want 25 %0d",
                   i, gt[i+1] - gt[i], ds[i], es[i]);
        end
      end
    end
    wait_idle();
  endtask

  task automatic test_latch_ignore();
    data_a[7:0] = 8'd200;
    sgn_a = '0;
    req_a = 4'b0001;
    tick();
    req_a = '0;
    for (int i = 0; i < 8; i++) begin
      data_a = $urandom;
      sgn_a = 4'($urandom);
      tick();
    end
    n_chk++;
    if (done_a !== 1'b1 || hun_a !== 4'd2 || ten_a !== 4'd0 ||
        one_a !== 4'd0 || neg_a !== 1'b0) begin
      n_fail++;
      $display("FAIL latch_hold d=%b got %0d%0d%0d n=%b want 1 200 0",
               done_a, hun_a, ten_a, one_a, neg_a);
    end
    sgn_a = '0;
    wait_idle();
  endtask

  task automatic test_mid_reset();
    data_a[7:0] = 8'd99;
    sgn_a = '0;
    req_a = 4'b0001;
    tick();
    req_a = '0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_chk++;
    if ({grant_a, busy_a, done_a, src_a, hun_a, ten_a, one_a, neg_a}
        !== '0) begin
      n_fail++;
      $display("FAIL mid_reset b=%b d=%b %0d%0d%0d want all 0",
               busy_a, done_a, hun_a, ten_a, one_a);
    end
    rst = 1'b0;
    req_a = 4'b1111;
    tick();
    req_a = '0;
    n_chk++;
    if (grant_a !== 4'b0001) begin
      n_fail++;
      $display("FAIL ptr_after_reset got %b want 0001", grant_a);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int gt [3];
    int t = 0, ng = 0, bad = 0, nd = 0;
    logic pend = 1'b0;
    data_b[7:0] = 8'd37;
    sgn_b = '0;
    req_b = 4'b0001;
    while (ng < 3 && t < 60) begin
      tick();
      t++;
      if (pend && grant_b !== 4'b0001) bad++;
      pend = 1'b0;
      if (grant_b != 4'b0000) begin
        gt[ng] = t;
        ng++;
      end
      if (done_b) begin
        nd++;
        pend = 1'b1;
        if (busy_b !== 1'b0 || hun_b !== 4'd0 || ten_b !== 4'd3 ||
            one_b !== 4'd7) bad++;
      end
    end
    req_b = '0;
    n_chk++;
    if (ng != 3 || nd != 2 || bad != 0) begin
      n_fail++;
      $display("FAIL b2b grants=%0d dones=%0d bad=%0d want 3 2 0",
               ng, nd, bad);
    end else begin
      n_chk++;
      if (gt[1] - gt[0] != 9 || gt[2] - gt[1] != 9) begin
        n_fail++;
        $display("FAIL b2b_gap got %0d %0d want 9 9",
                 gt[1] - gt[0], gt[2] - gt[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_round_robin();
    test_latch_ignore();
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_conv_sched.md
Name: disp_conv_sched

Overview:
- Round-robin scheduler that shares one sequential binary-to-BCD converter among NREQ 8-bit display sources, such as the accumulator, PC and ALU result.
- Grants one requester at a time and latches its byte and signed flag.
- Runs an 8-step add-3/shift conversion, one step per cycle.
- Presents hundreds/tens/ones BCD plus a sign flag to the downstream bcd_to_7led decoders, then holds the result for a programmable display time before re-arbitrating.

Parameters:
NREQ, 4, number of requesters (2..8)
HOLD_CYCLES, 16, cycles the result is held after done before the next arbitration (0 = no hold)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req  in  NREQ  level request, bit i = requester i
data_in  in  8*NREQ  packed bytes, requester i at [8i+7:8i]
signed_in  in  NREQ  bit i: interpret requester i byte as two's complement
grant  out  NREQ  one-hot, one-cycle pulse when requester's data is latched
busy  out  1  high from latch edge until return to IDLE
done  out  1  one-cycle pulse when digit outputs update
src  out  3  index of requester whose result is displayed
hundreds  out  4  BCD hundreds digit
tens  out  4  BCD tens digit
ones  out  4  BCD ones digit
negative  out  1  displayed value is negative

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- Reset (also mid-operation) forces:
  - grant=0, busy=0, done=0, src=0;
  - hundreds/tens/ones=0, negative=0;
  - FSM to IDLE, iteration counter and hold counter to 0;
  - round-robin pointer so that requester 0 has highest priority.
- FSM states: IDLE, CONV, HOLD.
- IDLE, req!=0 at edge E0:
  - Pick the first set req bit searching upward (with wrap) from pointer; the pointer is the last granted index +1.
  - Latch data_in slice and signed_in bit.
  - grant[k]=1 for exactly the cycle after E0.
  - busy=1; state CONV, iter=0; pointer=k+1 mod NREQ.
- Sign rule at latch:
  - If signed_in[k] and byte[7]=1: magnitude = two's-complement negation (9-bit safe; 8'h80 gives 128) and neg_latched=1.
  - Otherwise magnitude = byte and neg_latched=0.
- CONV:
  - 20-bit shift register, magnitude in [7:0].
  - Each cycle, add 3 to any of nibbles [11:8], [15:12], [19:16] that is >4, then shift left 1.
  - iter increments each cycle; the 8th step occurs at edge E8.
- At E8:
  - hundreds/tens/ones from [19:16]/[15:12]/[11:8], negative=neg_latched, src=k.
  - done=1 for the following cycle.
  - If HOLD_CYCLES=0, go to IDLE (busy=0); else go to HOLD with hold counter=HOLD_CYCLES.
- HOLD: decrement each cycle; on reaching 1, go to IDLE at that edge and set busy=0.
- Latency:
  - grant visible in cycle E0+1.
  - digits and done visible in cycle E8+1.
  - next grant edge is no earlier than E8+HOLD_CYCLES+1.
- Digit outputs change only at E8-type edges; they hold the last result indefinitely otherwise.
- data_in/signed_in changes after E0 are ignored.
- req deasserted before arbitration is simply not served. A req held after its grant is served again when the round-robin reaches it.
- Simultaneous requests are served in round-robin order; no requester starves.
- Results are always ≤255 (unsigned) or ≤128 (signed magnitude); no BCD digit exceeds 9.

Decomposition:
- Shared package disp_pkg:
  - state enum (IDLE/CONV/HOLD);
  - BCD_W=4, DATA_W=8, CONV_STEPS=8;
  - helper function for the add-3 nibble correction.
- One natural sub-module, disp_rr_arbiter. It is combinational, with inputs req and pointer and outputs a one-hot pick plus its index; the pointer register lives in the parent.

Test Plan:
- Reset, then req=0010, data1=8'hFF, signed=0 -> grant=0010 for one cycle; after 8 cycles done=1 with hundreds=2, tens=5, ones=5, negative=0, src=1.
- req0 signed: 8'hFF -> 0/0/1 neg=1; 8'h80 -> 1/2/8 neg=1; 8'h7F -> 1/2/7 neg=0; 8'h00 -> 0/0/0 neg=0.
- req=0101 held, HOLD_CYCLES=16 -> grants alternate 0001, 0100, 0001, …; successive grants spaced exactly 1+8+16=25 cycles; src alternates 0,2.
- After grant, change data_in every cycle during CONV -> result reflects only the byte present at the latch edge.
- Assert rst on the 4th CONV cycle -> next cycle all outputs 0, busy=0; with req=1111 afterwards the first grant is 0001.
- HOLD_CYCLES=0, req0 held -> back-to-back conversions, grant every 9 cycles, done each followed by the next grant edge in IDLE.
